radix4_recon_mac: RTL and testbench



---
 rtl/radix4_recon_mac.sv | 113 +++++++++++
 tb/tb_radix4_recon_mac.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/radix4_recon_mac.sv
// Radix-4 sequential multiply-accumulate that rebuilds a dividend as Q*D + R
// from a divider result and checks it against the expected dividend.
module radix4_recon_mac #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Q,
  input  logic [WIDTH-1:0]     D,
  input  logic [WIDTH-1:0]     R,
  input  logic [WIDTH-1:0]     N_exp,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P,
  output logic                 match
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADD  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   qreg, dreg, rreg, nreg;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH+1:0]   pp;
  logic [2*WIDTH-1:0] sum;

  // Radix-4 digit times divisor; 3D is formed as D + 2D, no multiplier needed.
  function automatic logic [WIDTH+1:0] digit_pp(input logic [1:0] digit,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH+1:0] d1, d2;
    d1 = {2'b00, d};
    d2 = {1'b0, d, 1'b0};
    case (digit)
      2'd0:    digit_pp = '0;
      2'd1:    digit_pp = d1;
      2'd2:    digit_pp = d2;
      default: digit_pp = d1 + d2;
    endcase
  endfunction

  assign pp  = digit_pp(qreg[WIDTH-1 -: 2], dreg);
  assign sum = acc + (2*WIDTH)'(rreg);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? CALC : IDLE;
      CALC:    state_next = (cnt == LAST_DIGIT) ? ADD : CALC;
      ADD:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      qreg  <= '0;
      dreg  <= '0;
      rreg  <= '0;
      nreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      P     <= '0;
      match <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            qreg <= Q;
            dreg <= D;
            rreg <= R;
            nreg <= N_exp;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        // Digit stage: shift accumulator one radix-4 position, add digit*D.
        CALC: begin
          acc  <= (acc << 2) + (2*WIDTH)'(pp);
          qreg <= qreg << 2;
          cnt  <= cnt + CNT_W'(1);
        end
        // Result stage: fold in remainder and compare with expected dividend.
        ADD: begin
          P     <= sum;
          match <= (sum == (2*WIDTH)'(nreg));
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_recon_mac.sv
// Directed bench for radix4_recon_mac (WIDTH=8): latency, values, start
// handling, async reset abort and a divider-consistency sweep.
module tb_radix4_recon_mac;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  q, d, r, n_exp;
  logic        busy, done, match;
  logic [15:0] p;

  int tests = 0;
  int fails = 0;

  radix4_recon_mac #(.WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .Q(q), .D(d), .R(r), .N_exp(n_exp),
    .busy(busy), .done(done), .P(p), .match(match)
  );

  always #5 clk = ~clk;

  // Drive operands and start; returns at the falling edge after acceptance.
  task automatic launch(input logic [7:0] qi, di, ri, ni, input bit hold);
    @(negedge clk);
    q = qi; d = di; r = ri; n_exp = ni; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Counts falling edges until done, bounded; also counts busy-high samples.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; q = '0; d = '0; r = '0; n_exp = '0;
    @(negedge clk);
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (p !== 16'h0000) begin fails++; $display("FAIL reset_P: got %h want 0000", p); end
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL reset_match: got %b want 0", match); end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int n, bn;
    launch(8'h0C, 8'h0A, 8'h05, 8'h7D, 1'b0);
    wait_done(n, bn);
    tests++; if (n !== 5)         begin fails++; $display("FAIL basic_latency: got %0d want 5", n); end
    tests++; if (bn !== 5)        begin fails++; $display("FAIL basic_busy_cycles: got %0d want 5", bn); end
    tests++; if (p !== 16'h007D)  begin fails++; $display("FAIL basic_P: got %h want 007d", p); end
    tests++; if (match !== 1'b1)  begin fails++; $display("FAIL basic_match: got %b want 1", match); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0)   begin fails++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    tests++; if (p !== 16'h007D)  begin fails++; $display("FAIL basic_P_held: got %h want 007d", p); end
  endtask

  task automatic test_boundaries();
    int n, bn;
    launch(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
    wait_done(n, bn);
    tests++; if (p !== 16'hFF00)  begin fails++; $display("FAIL max_P: got %h want ff00", p); end
    tests++; if (match !== 1'b0)  begin fails++; $display("FAIL max_match: got %b want 0", match); end
    launch(8'hFF, 8'h00, 8'h33, 8'h33, 1'b0);
    wait_done(n, bn);
    tests++; if (p !== 16'h0033)  begin fails++; $display("FAIL dzero_P: got %h want 0033", p); end
    tests++; if (match !== 1'b1)  begin fails++; $display("FAIL dzero_match: got %b want 1", match); end
    launch(8'h00, 8'h55, 8'h12, 8'h12, 1'b0);
    wait_done(n, bn);
    tests++; if (p !== 16'h0012)  begin fails++; $display("FAIL qzero_P: got %h want 0012", p); end
  endtask

  task automatic test_back_to_back();
    int n, bn;
    launch(8'h03, 8'h03, 8'h00, 8'h09, 1'b1);
    q = 8'hAA; d = 8'h55; r = 8'h11; n_exp = 8'h77;
    wait_done(n, bn);
    tests++; if (n !== 5)         begin fails++; $display("FAIL b2b_latency1: got %0d want 5", n); end
    tests++; if (p !== 16'h0009)  begin fails++; $display("FAIL b2b_P1: got %h want 0009", p); end
    tests++; if (match !== 1'b1)  begin fails++; $display("FAIL b2b_match1: got %b want 1", match); end
    q = 8'h03; d = 8'h03; r = 8'h00; n_exp = 8'h09;
    @(negedge clk);
    tests++; if (busy !== 1'b1)   begin fails++; $display("FAIL b2b_reaccept_busy: got %b want 1", busy); end
    tests++; if (done !== 1'b0)   begin fails++; $display("FAIL b2b_reaccept_done: got %b want 0", done); end
    q = 8'hAA; d = 8'h55;
    wait_done(n, bn);
    start = 1'b0;
    tests++; if (n !== 5)         begin fails++; $display("FAIL b2b_latency2: got %0d want 5", n); end
    tests++; if (p !== 16'h0009)  begin fails++; $display("FAIL b2b_P2: got %h want 0009", p); end
  endtask

  task automatic test_start_while_busy();
    int pulses = 0;
    int lat = 0;
    logic [15:0] p_seen = '0;
    launch(8'h05, 8'h06, 8'h01, 8'h1F, 1'b0);
    q = 8'hF0; d = 8'h0F; r = 8'h22; n_exp = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (pulses == 1) begin lat = i; p_seen = p; end
      end
    end
    tests++; if (pulses !== 1)       begin fails++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
    tests++; if (lat !== 5)          begin fails++; $display("FAIL ignore_latency: got %0d want 5", lat); end
    tests++; if (p_seen !== 16'h001F) begin fails++; $display("FAIL ignore_P: got %h want 001f", p_seen); end
  endtask

  task automatic test_async_reset();
    int n, bn;
    int pulses = 0;
    launch(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    tests++; if (p !== 16'h0000) begin fails++; $display("FAIL areset_P: got %h want 0000", p); end
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL areset_match: got %b want 0", match); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL areset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0)  begin fails++; $display("FAIL areset_done: got %b want 0", done); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    tests++; if (pulses !== 0)   begin fails++; $display("FAIL areset_no_result: got %0d want 0", pulses); end
    launch(8'h05, 8'h07, 8'h02, 8'h25, 1'b0);
    wait_done(n, bn);
    tests++; if (n !== 5)         begin fails++; $display("FAIL areset_fresh_latency: got %0d want 5", n); end
    tests++; if (p !== 16'h0025)  begin fails++; $display("FAIL areset_fresh_P: got %h want 0025", p); end
    tests++; if (match !== 1'b1)  begin fails++; $display("FAIL areset_fresh_match: got %b want 1", match); end
  endtask

  task automatic test_divider_sweep();
    int n, bn, nn, dd, qq, rr;
    for (int k = 0; k < 10; k++) begin
      nn = $urandom_range(0, 255);
      dd = $urandom_range(1, 255);
      qq = nn / dd;
      rr = nn % dd;
      launch(8'(qq), 8'(dd), 8'(rr), 8'(nn), 1'b0);
      wait_done(n, bn);
      tests++; if (match !== 1'b1) begin fails++; $display("FAIL sweep_match: N=%0d D=%0d got %b want 1", nn, dd, match); end
      tests++; if (p !== 16'(nn))  begin fails++; $display("FAIL sweep_P: N=%0d D=%0d got %h want %h", nn, dd, p, 16'(nn)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_start_while_busy();
    test_async_reset();
    test_divider_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
